serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 60 ++++++
 tb/tb_serializer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/serializer.sv
// serializer: MSB-first parallel-to-serial converter with a variable bit count
module serializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [MOD_W:0]    len_q;
  logic [MOD_W:0]    cnt;
  logic [MOD_W:0]    n;
  logic [MOD_W-1:0]  idx;
  logic              accept;
  // effective length, acceptance (lengths 1 and 2 are dropped) and current bit index
  always_comb begin
    n      = (data_mod_i == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, data_mod_i};
    accept = data_val_i && (n >= (MOD_W+1)'(3));
    idx    = MOD_W'(DATA_W - 1) - cnt[MOD_W-1:0];
  end
  // FSM: the first bit is registered on the accepting edge, the word stays frozen until done
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state          <= IDLE;
      data_q         <= '0;
      len_q          <= '0;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        state          <= SEND;
        data_q         <= data_i;
        len_q          <= n;
        cnt            <= (MOD_W+1)'(1);
        ser_data_o     <= data_i[DATA_W-1];
        ser_data_val_o <= 1'b1;
        busy_o         <= 1'b1;
      end
    end else if (cnt == len_q) begin
      state          <= IDLE;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      ser_data_o <= data_q[idx];
      cnt        <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed scoreboard bench for the serializer
module tb_serializer;
  logic        clk_i = 1'b0;
  logic        srst_n_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o, ser_data_val_o, busy_o;
  int          checks = 0;
  int          passed = 0;
  logic        exp_q[$];

  serializer #(.DATA_W(16)) dut (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .ser_data_o(ser_data_o), .ser_data_val_o(ser_data_val_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // expected bits for a request: MSB first, nothing for lengths 1 and 2
  task automatic push_word(input logic [15:0] d, input logic [3:0] m);
    int n;
    n = (m == 0) ? 16 : int'(m);
    if (n >= 3) for (int k = 0; k < n; k++) exp_q.push_back(d[15-k]);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] m);
    @(posedge clk_i); #1;
    data_i = d; data_mod_i = m; data_val_i = 1'b1;
    push_word(d, m);
    @(posedge clk_i); #1;
    data_val_i = 1'b0; data_i = 16'hDEAD;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while ((exp_q.size() != 0 || busy_o) && t < 40);
    chk("drain", 32'(exp_q.size() != 0 || busy_o), 0);
    exp_q.delete();
  endtask

  // monitor: every cycle check framing invariants, pop and compare on each valid bit
  always @(negedge clk_i) begin
    chk("busy_eq_val", 32'(busy_o), 32'(ser_data_val_o));
    if (ser_data_val_o) begin
      if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
      else chk("ser_bit", 32'(ser_data_o), 32'(exp_q.pop_front()));
    end else chk("ser_zero_idle", 32'(ser_data_o), 0);
  end

  initial begin
    data_val_i = 1'b1;
    data_i = 16'hFFFF;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_val", 32'(ser_data_val_o), 0);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_ser", 32'(ser_data_o), 0);
    @(posedge clk_i); #1;
    srst_n_i = 1'b1; data_val_i = 1'b0;
    repeat (3) @(posedge clk_i);
    send(16'hA5C3, 4'd0);
    wait_idle();
    send(16'hF000, 4'd3);
    wait_idle();
    send(16'hFFFF, 4'd1);
    send(16'hFFFF, 4'd2);
    repeat (4) @(negedge clk_i);
    chk("drop_busy", 32'(busy_o), 0);
    send(16'h8001, 4'd4);
    wait_idle();
    send(16'h7FFE, 4'd15);
    wait_idle();
    // held request with changing data during a full word
    @(posedge clk_i); #1;
    data_i = 16'hA5C3; data_mod_i = 4'd0; data_val_i = 1'b1;
    push_word(16'hA5C3, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_i); #1;
      data_i = 16'(i * 16'h1111); data_mod_i = 4'd3;
    end
    @(posedge clk_i); #1;
    data_i = 16'h1234; data_mod_i = 4'd0;
    push_word(16'h1234, 4'd0);
    @(negedge clk_i);
    chk("gap_busy_low", 32'(busy_o), 0);
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
    @(negedge clk_i);
    chk("next_accept", 32'(busy_o), 1);
    wait_idle();
    // reset at bit 5 aborts the word
    send(16'hA5C3, 4'd0);
    repeat (4) @(posedge clk_i);
    #1 srst_n_i = 1'b0;
    @(posedge clk_i); #1;
    srst_n_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    chk("abort_val", 32'(ser_data_val_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_ser", 32'(ser_data_o), 0);
    repeat (4) @(posedge clk_i);
    send(16'h5A3C, 4'd0);
    wait_idle();
    send(16'hC0DE, 4'd9);
    wait_idle();
    send(16'h0001, 4'd0);
    wait_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
